// File: rtl/arbiter_request_fifo_pkg.sv
// rtl/arbiter_request_fifo_pkg.sv - shared types and helpers for the arbiter request FIFO
package arb_fifo_pkg;

  localparam int ARB_FIFO_STAT_W = 32;

  typedef struct packed {
    logic [ARB_FIFO_STAT_W-1:0] push_cnt;
    logic [ARB_FIFO_STAT_W-1:0] drop_cnt;
    logic [ARB_FIFO_STAT_W-1:0] max_occ;
  } arb_fifo_stats_t;

  // Saturating increment: counters park at all-ones instead of wrapping.
  function automatic logic [ARB_FIFO_STAT_W-1:0] sat_inc(input logic [ARB_FIFO_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arbiter_request_fifo_storage.sv
// rtl/arbiter_request_fifo_storage.sv - DEPTH x WIDTH register array, sync write, async read
module arb_fifo_storage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [0:WIDTH-1] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [0:WIDTH-1] rd_data
);

  logic [0:WIDTH-1] mem [DEPTH];

  // No reset on the array: the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/arbiter_request_fifo.sv
// rtl/arbiter_request_fifo.sv - per-requester FIFO feeding one arbiter input
// Optional statistics outputs are built when ARB_FIFO_STATS_EN is defined.
module arbiter_request_fifo
  import arb_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enabled,
  input  logic                     push,
  input  logic [0:WIDTH-1]         data_in,
  output logic                     full,
  output logic                     almost_full,
  output logic                     request,
  output logic [0:WIDTH-1]         data_out,
  input  logic                     ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
`ifdef ARB_FIFO_STATS_EN
  ,
  output logic [31:0]              stat_push_cnt,
  output logic [31:0]              stat_drop_cnt,
  output logic [$clog2(DEPTH):0]   stat_max_occ
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    next_count;
  logic [0:WIDTH-1] head;
  logic             pop, wr;

  arb_fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clock   (clock),
    .wr_en   (wr),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= PW'(AFULL_LEVEL));

  assign pop        = ready & ~empty;
  assign wr         = push & (~full | pop);
  assign next_count = count + PW'(wr) - PW'(pop);

  assign request  = ~empty & enabled;
  assign data_out = empty ? '0 : head;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & full & ~pop) overflow  <= 1'b1;
      if (ready & empty)      underflow <= 1'b1;
    end
  end

`ifdef ARB_FIFO_STATS_EN
  arb_fifo_stats_t stats;

  always_ff @(posedge clock) begin
    if (reset) begin
      stats <= '0;
    end else begin
      if (wr)          stats.push_cnt <= sat_inc(stats.push_cnt);
      if (push & ~wr)  stats.drop_cnt <= sat_inc(stats.drop_cnt);
      if (ARB_FIFO_STAT_W'(next_count) > stats.max_occ)
        stats.max_occ <= ARB_FIFO_STAT_W'(next_count);
    end
  end

  assign stat_push_cnt = stats.push_cnt;
  assign stat_drop_cnt = stats.drop_cnt;
  assign stat_max_occ  = stats.max_occ[PW-1:0];
`endif

endmodule

// File: tb/tb_arbiter_request_fifo.sv
// tb/tb_arbiter_request_fifo.sv - scoreboard bench for arbiter_request_fifo (DEPTH 16, WIDTH 8)
module tb_arbiter_request_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        enabled;
  logic        push;
  logic [0:7]  data_in;
  logic        full, almost_full, request, empty, overflow, underflow;
  logic [0:7]  data_out;
  logic        ready;
  logic [4:0]  count;
`ifdef ARB_FIFO_STATS_EN
  logic [31:0] stat_push_cnt, stat_drop_cnt;
  logic [4:0]  stat_max_occ;
`endif

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;
  logic [7:0] sb[$];

  arbiter_request_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
    .clock       (clock),
    .reset       (reset),
    .enabled     (enabled),
    .push        (push),
    .data_in     (data_in),
    .full        (full),
    .almost_full (almost_full),
    .request     (request),
    .data_out    (data_out),
    .ready       (ready),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef ARB_FIFO_STATS_EN
    ,
    .stat_push_cnt (stat_push_cnt),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_max_occ  (stat_max_occ)
`endif
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle that the DUT pops, the head must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && ready && !empty) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got %0h expected no pop", data_out);
      end else begin
        check("pop_data", {24'h0, data_out}, {24'h0, sb.pop_front()});
      end
    end
  end

  // One clock cycle of stimulus; expected entries are queued when the model says the push is accepted.
  task automatic cyc(input logic p, input logic [7:0] d, input logic r);
    logic pop_m, acc;
    pop_m = r && (model_cnt > 0);
    acc   = p && ((model_cnt < 16) || pop_m);
    if (acc) sb.push_back(d);
    model_cnt = model_cnt + int'(acc) - int'(pop_m);
    push    = p;
    data_in = d;
    ready   = r;
    @(posedge clock);
    #1;
    push  = 1'b0;
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enabled = 1'b1; push = 1'b0; ready = 1'b0; data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    check("rst_request", 32'(request), 0);
    check("rst_data_out", 32'(data_out), 0);

    // 1: single push, visible next cycle, popped by ready
    cyc(1'b1, 8'hA5, 1'b0);
    check("t1_request", 32'(request), 1);
    check("t1_head", 32'(data_out), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_empty", 32'(empty), 1);
    check("t1_req_low", 32'(request), 0);
    check("t1_data_zero", 32'(data_out), 0);

    // 2: fill to 16, almost_full from 12, 17th push dropped
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      check("t2_afull", 32'(almost_full), (i + 1 >= 12) ? 1 : 0);
    end
    check("t2_full", 32'(full), 1);
    check("t2_count", 32'(count), 16);
    check("t2_ovf_pre", 32'(overflow), 0);
    cyc(1'b1, 8'hEE, 1'b0);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_hold", 32'(count), 16);
    check("t2_head", 32'(data_out), 32'h10);

    // 3: push+pop while full keeps count, 3C reaches head after 15 pops
    cyc(1'b1, 8'h3C, 1'b1);
    check("t3_count", 32'(count), 16);
    check("t3_full", 32'(full), 1);
`ifdef ARB_FIFO_STATS_EN
    check("t3_stat_push", stat_push_cnt, 18);
    check("t3_stat_drop", stat_drop_cnt, 1);
    check("t3_stat_max", 32'(stat_max_occ), 16);
`endif
    repeat (15) cyc(1'b0, 8'h00, 1'b1);
    check("t3_head_3c", 32'(data_out), 32'h3C);
    check("t3_count1", 32'(count), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_empty", 32'(empty), 1);

    // 4: pointer wrap with 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("t4_empty", 32'(empty), 1);
    check("t4_count", 32'(count), 0);
    check("t4_unf", 32'(underflow), 0);

    // 5: enabled gating, pop while disabled, underflow, push+pop on empty
    cyc(1'b1, 8'h51, 1'b0);
    cyc(1'b1, 8'h52, 1'b0);
    cyc(1'b1, 8'h53, 1'b0);
    enabled = 1'b0;
    #1;
    check("t5_req_dis", 32'(request), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_pop_dis", 32'(count), 2);
    enabled = 1'b1;
    #1;
    check("t5_req_en", 32'(request), 1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_empty", 32'(empty), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_unf", 32'(underflow), 1);
    check("t5_count0", 32'(count), 0);
    cyc(1'b1, 8'h77, 1'b1);
    check("t5_pushpop_empty", 32'(count), 1);
    check("t5_head77", 32'(data_out), 32'h77);

    // 6: reset with 5 entries discards everything
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    check("t6_count5", 32'(count), 5);
    reset = 1'b1;
    sb.delete();
    model_cnt = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_request", 32'(request), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_unf", 32'(underflow), 0);
    check("t6_data_zero", 32'(data_out), 0);
`ifdef ARB_FIFO_STATS_EN
    check("t6_stat_push", stat_push_cnt, 0);
    check("t6_stat_drop", stat_drop_cnt, 0);
    check("t6_stat_max", 32'(stat_max_occ), 0);
`endif

    repeat (2) @(posedge clock);
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
